repair_sb_arbiter: RTL and testbench
====================================

// Module: repair_sb_arbiter
// PURPOSE
//  Shares the single MBTRAIN.REPAIR sideband transmit port between the repair TX and repair RX
//  sub-state machines, replacing the OR/mux merge of their valid and message outputs.
//  Grants one requester at a time (round-robin) and registers its message onto the sideband.
//  Holds the grant until the sideband reports completion (busy falling edge), then acknowledges.
//  Flags a timeout when the sideband never completes.
// PARAMETERS
//  MSG_W          4     width of sideband message code
//  ENC_W          3     width of data-lanes encoding field
//  HOLD_TIMEOUT   1024  max cycles in WAIT without busy falling edge before timeout (>=2)
// PORTS
//  clk                             in   1      clock
//  rst_n                           in   1      synchronous active-low reset
//  i_en                            in   1      block enable; low = synchronous soft reset
//  i_tx_valid                      in   1      repair TX requests a send; held until o_tx_done
//  i_tx_message                    in   MSG_W  repair TX message; stable while i_tx_valid
//  i_tx_lanes_encoding             in   ENC_W  repair TX lanes encoding; stable while i_tx_valid
//  i_rx_valid                      in   1      repair RX requests a send; held until o_rx_done
//  i_rx_message                    in   MSG_W  repair RX message; stable while i_rx_valid
//  i_busy                          in   1      sideband TX busy
//  i_falling_edge_busy             in   1      1-cycle pulse: sideband finished current message
//  o_valid                         out  1      1-cycle pulse: message/encoding valid to sideband
//  o_sideband_message              out  MSG_W  registered granted message
//  o_sideband_data_lanes_encoding  out  ENC_W  registered encoding (0 when RX granted)
//  o_tx_done                       out  1      1-cycle pulse: TX message completed
//  o_rx_done                       out  1      1-cycle pulse: RX message completed
//  o_timeout                       out  1      sticky: WAIT exceeded HOLD_TIMEOUT
// BEHAVIOUR
//  - All outputs registered.
//  - Reset (rst_n=0 at clk edge) and i_en=0 (same effect, same cycle): state=IDLE; all outputs 0;
//    RR pointer=TX; timeout counter=0.
//  - FSM states:
//    - IDLE: if !i_busy and any valid, grant and go ISSUE.
//      - Both valid: grant the requester the pointer selects.
//      - One valid: grant it regardless of pointer.
//      - On grant, latch message/encoding into output regs, assert o_valid next cycle.
//      - i_busy=1: no grant.
//    - ISSUE: o_valid=1 for exactly this cycle; go WAIT; clear counter.
//      - i_falling_edge_busy in this cycle is ignored (belongs to a prior message).
//    - WAIT: counter increments each cycle.
//      - i_falling_edge_busy=1 -> next cycle: done pulse for granted requester, pointer set to the
//        other requester, state IDLE.
//      - Counter reaches HOLD_TIMEOUT-1 with no edge -> next cycle: o_timeout=1 (sticky until
//        reset/i_en=0), state IDLE, no done pulse, pointer advanced.
//      - Edge and limit in the same cycle: edge wins (done, no timeout).
//  - Latency:
//    - Valid sampled in IDLE at cycle N -> o_valid high at N+1.
//    - Edge sampled at cycle M -> done at M+1; earliest next o_valid at M+2.
//  - o_sideband_message/encoding hold their value after ISSUE until the next grant.
//  - Requester dropping valid before grant: no effect. Dropping valid after grant: message still
//    completes and done still pulses.
//  - A requester that re-asserts valid in the cycle of its done is eligible in the next IDLE cycle,
//    subject to the pointer.
//  - Counter width $clog2(HOLD_TIMEOUT); saturates, never wraps.
// TESTING
//  - Reset: rst_n=0 two cycles with both valids high -> all outputs 0, no o_valid.
//  - Single TX: tx_valid, msg=4'h3, enc=3'b101 -> o_valid at +1 with 4'h3/101.
//    Edge 5 cycles later -> o_tx_done 1 cycle after edge.
//  - Contention: both valid from reset -> TX first (msg 4'h3), then RX (msg 4'h7, enc 000).
//    TX re-requests -> order TX, RX, TX; never same requester twice while the other waits.
//  - Busy gate: i_busy=1 with tx_valid -> no o_valid until i_busy=0, then o_valid next cycle.
//    Edge in ISSUE cycle ignored; only a WAIT edge gives o_tx_done.
//  - Timeout: HOLD_TIMEOUT=8, no edge -> o_timeout=1 8 cycles after entering WAIT, no done.
//    o_timeout stays set until i_en=0.
//  - Mid-op disable: i_en=0 during WAIT -> next cycle all outputs 0, IDLE.
//    Later edge produces no done.

Source files
------------

// File: rtl/repair_sb_arbiter.sv
// -----------------------------------------------------------------------------
// repair_sb_arbiter
//
// Shares the single MBTRAIN.REPAIR sideband transmit port between the repair
// TX and repair RX sub-state machines. One requester is granted at a time,
// chosen round-robin when both request. Its message and encoding are
// registered onto the sideband with a one-cycle o_valid pulse. The grant is
// held until the sideband signals completion (busy falling edge), and the
// owner is then acknowledged with a done pulse. If the sideband never
// completes, the arbiter flags a sticky timeout and returns to IDLE.
//
// Ports
//   clk                             clock
//   rst_n                           synchronous active-low reset
//   i_en                            block enable; low acts as a synchronous soft reset
//   i_tx_valid / i_tx_message /
//   i_tx_lanes_encoding             repair TX request, held until o_tx_done
//   i_rx_valid / i_rx_message       repair RX request, held until o_rx_done
//   i_busy                          sideband TX busy; blocks new grants
//   i_falling_edge_busy             1-cycle pulse: sideband finished current message
//   o_valid                         1-cycle pulse: message/encoding valid to sideband
//   o_sideband_message              registered granted message
//   o_sideband_data_lanes_encoding  registered encoding (0 when RX granted)
//   o_tx_done / o_rx_done           1-cycle completion pulses
//   o_timeout                       sticky: WAIT exceeded HOLD_TIMEOUT cycles
// -----------------------------------------------------------------------------
module repair_sb_arbiter #(
  parameter int MSG_W        = 4,
  parameter int ENC_W        = 3,
  parameter int HOLD_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  input  logic             i_tx_valid,
  input  logic [MSG_W-1:0] i_tx_message,
  input  logic [ENC_W-1:0] i_tx_lanes_encoding,
  input  logic             i_rx_valid,
  input  logic [MSG_W-1:0] i_rx_message,
  input  logic             i_busy,
  input  logic             i_falling_edge_busy,
  output logic             o_valid,
  output logic [MSG_W-1:0] o_sideband_message,
  output logic [ENC_W-1:0] o_sideband_data_lanes_encoding,
  output logic             o_tx_done,
  output logic             o_rx_done,
  output logic             o_timeout
);

  localparam int CNT_W = (HOLD_TIMEOUT > 1) ? $clog2(HOLD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(HOLD_TIMEOUT - 1);

  // Requester identity, used for both the round-robin pointer and the grant.
  localparam logic REQ_TX = 1'b0;
  localparam logic REQ_RX = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;

  state_t             state_r,   state_s;
  logic               ptr_r,     ptr_s;
  logic               grant_r,   grant_s;
  logic [CNT_W-1:0]   cnt_r,     cnt_s;
  logic               valid_r,   valid_s;
  logic [MSG_W-1:0]   msg_r,     msg_s;
  logic [ENC_W-1:0]   enc_r,     enc_s;
  logic               tx_done_r, tx_done_s;
  logic               rx_done_r, rx_done_s;
  logic               timeout_r, timeout_s;
  logic               pick_rx_s;

  // Requester selection: the pointer only matters when both are asking.
  always_comb begin
    pick_rx_s = REQ_TX;
    if (i_tx_valid && i_rx_valid) begin
      pick_rx_s = ptr_r;
    end else if (i_rx_valid) begin
      pick_rx_s = REQ_RX;
    end else begin
      pick_rx_s = REQ_TX;
    end
  end

  // Next-state and next-output logic; pulses default low every cycle.
  always_comb begin
    state_s   = state_r;
    ptr_s     = ptr_r;
    grant_s   = grant_r;
    cnt_s     = cnt_r;
    valid_s   = 1'b0;
    msg_s     = msg_r;
    enc_s     = enc_r;
    tx_done_s = 1'b0;
    rx_done_s = 1'b0;
    timeout_s = timeout_r;

    case (state_r)
      ST_IDLE: begin
        if (!i_busy && (i_tx_valid || i_rx_valid)) begin
          grant_s = pick_rx_s;
          valid_s = 1'b1;
          state_s = ST_ISSUE;
          if (pick_rx_s == REQ_RX) begin
            msg_s = i_rx_message;
            enc_s = '0;
          end else begin
            msg_s = i_tx_message;
            enc_s = i_tx_lanes_encoding;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end

      // A busy falling edge seen here belongs to a previous message, so it
      // is deliberately not looked at.
      ST_ISSUE: begin
        state_s = ST_WAIT;
        cnt_s   = '0;
      end

      // Completion takes priority over the timeout limit in the same cycle.
      ST_WAIT: begin
        if (i_falling_edge_busy) begin
          tx_done_s = (grant_r == REQ_TX);
          rx_done_s = (grant_r == REQ_RX);
          ptr_s     = ~grant_r;
          state_s   = ST_IDLE;
        end else if (cnt_r == CNT_LIMIT) begin
          timeout_s = 1'b1;
          ptr_s     = ~grant_r;
          state_s   = ST_IDLE;
        end else begin
          cnt_s = cnt_r + CNT_W'(1);
        end
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset and disable clear everything alike.
  always_ff @(posedge clk) begin
    if (!rst_n || !i_en) begin
      state_r   <= ST_IDLE;
      ptr_r     <= REQ_TX;
      grant_r   <= REQ_TX;
      cnt_r     <= '0;
      valid_r   <= 1'b0;
      msg_r     <= '0;
      enc_r     <= '0;
      tx_done_r <= 1'b0;
      rx_done_r <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      ptr_r     <= ptr_s;
      grant_r   <= grant_s;
      cnt_r     <= cnt_s;
      valid_r   <= valid_s;
      msg_r     <= msg_s;
      enc_r     <= enc_s;
      tx_done_r <= tx_done_s;
      rx_done_r <= rx_done_s;
      timeout_r <= timeout_s;
    end
  end

  assign o_valid                        = valid_r;
  assign o_sideband_message             = msg_r;
  assign o_sideband_data_lanes_encoding = enc_r;
  assign o_tx_done                      = tx_done_r;
  assign o_rx_done                      = rx_done_r;
  assign o_timeout                      = timeout_r;

endmodule

// File: tb/tb_repair_sb_arbiter.sv
// -----------------------------------------------------------------------------
// tb_repair_sb_arbiter
//
// Self-checking bench for repair_sb_arbiter (HOLD_TIMEOUT = 8). Expected
// sideband messages and expected done pulses are queued when stimulus is
// applied; negedge monitors pop and compare whenever the DUT emits o_valid or
// a done pulse. Directed checks cover latency, busy gating, timeout and
// disable behaviour.
// -----------------------------------------------------------------------------
module tb_repair_sb_arbiter;

  localparam int MSG_W = 4;
  localparam int ENC_W = 3;
  localparam int HOLD_TIMEOUT = 8;

  logic             clk;
  logic             rst_n;
  logic             i_en;
  logic             i_tx_valid;
  logic [MSG_W-1:0] i_tx_message;
  logic [ENC_W-1:0] i_tx_lanes_encoding;
  logic             i_rx_valid;
  logic [MSG_W-1:0] i_rx_message;
  logic             i_busy;
  logic             i_falling_edge_busy;
  logic             o_valid;
  logic [MSG_W-1:0] o_sideband_message;
  logic [ENC_W-1:0] o_sideband_data_lanes_encoding;
  logic             o_tx_done;
  logic             o_rx_done;
  logic             o_timeout;

  int errors = 0;
  int checks = 0;

  logic [MSG_W+ENC_W-1:0] exp_q[$];   // expected {message, encoding}
  logic [1:0]             done_q[$];  // expected {tx_done, rx_done}

  repair_sb_arbiter #(
    .MSG_W(MSG_W),
    .ENC_W(ENC_W),
    .HOLD_TIMEOUT(HOLD_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_en(i_en),
    .i_tx_valid(i_tx_valid),
    .i_tx_message(i_tx_message),
    .i_tx_lanes_encoding(i_tx_lanes_encoding),
    .i_rx_valid(i_rx_valid),
    .i_rx_message(i_rx_message),
    .i_busy(i_busy),
    .i_falling_edge_busy(i_falling_edge_busy),
    .o_valid(o_valid),
    .o_sideband_message(o_sideband_message),
    .o_sideband_data_lanes_encoding(o_sideband_data_lanes_encoding),
    .o_tx_done(o_tx_done),
    .o_rx_done(o_rx_done),
    .o_timeout(o_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] all_outs();
    return 32'({o_valid, o_sideband_message, o_sideband_data_lanes_encoding,
                o_tx_done, o_rx_done, o_timeout});
  endfunction

  // Scoreboard monitor: every o_valid must match the oldest expected send.
  always @(negedge clk) begin
    if (o_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_valid", 32'({o_sideband_message, o_sideband_data_lanes_encoding}), 32'hFFFF);
      end else begin
        check("sb_msg_enc", 32'({o_sideband_message, o_sideband_data_lanes_encoding}),
              32'(exp_q.pop_front()));
      end
    end
  end

  // Scoreboard monitor: every done pulse must match the oldest expected owner.
  always @(negedge clk) begin
    if ((o_tx_done === 1'b1) || (o_rx_done === 1'b1)) begin
      if (done_q.size() == 0) begin
        check("unexpected_done", 32'({o_tx_done, o_rx_done}), 32'd0);
      end else begin
        check("sb_done", 32'({o_tx_done, o_rx_done}), 32'(done_q.pop_front()));
      end
    end
  end

  task automatic wait_valid(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (o_valid === 1'b1) seen = 1'b1;
    end
    check("wait_valid", 32'(seen), 32'd1);
  endtask

  // Drive a single-cycle busy falling edge; returns at the negedge where the
  // resulting done pulse (if any) is visible.
  task automatic pulse_edge();
    i_falling_edge_busy = 1'b1;
    @(negedge clk);
    i_falling_edge_busy = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n               = 1'b0;
    i_en                = 1'b1;
    i_tx_valid          = 1'b1;
    i_tx_message        = 4'h3;
    i_tx_lanes_encoding = 3'b101;
    i_rx_valid          = 1'b1;
    i_rx_message        = 4'h7;
    i_busy              = 1'b0;
    i_falling_edge_busy = 1'b0;

    // Reset held two cycles with both requesters active.
    repeat (2) begin
      @(negedge clk);
      check("reset_outputs", all_outs(), 32'd0);
    end

    // Contention: TX first, then RX, then TX again.
    exp_q.push_back({4'h3, 3'b101});
    rst_n = 1'b1;
    @(negedge clk);
    check("first_valid_latency", 32'(o_valid), 32'd1);
    exp_q.push_back({4'h7, 3'b000});
    done_q.push_back(2'b10);
    repeat (2) @(negedge clk);
    pulse_edge();
    check("tx_done_latency", 32'(o_tx_done), 32'd1);

    wait_valid(4);
    exp_q.push_back({4'h3, 3'b101});
    done_q.push_back(2'b01);
    repeat (2) @(negedge clk);
    pulse_edge();
    check("rx_done_latency", 32'(o_rx_done), 32'd1);

    wait_valid(4);
    done_q.push_back(2'b10);
    repeat (2) @(negedge clk);
    pulse_edge();
    check("tx_done_round2", 32'(o_tx_done), 32'd1);
    i_tx_valid = 1'b0;
    i_rx_valid = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("idle_quiet", 32'(o_valid), 32'd0);
    end

    // Busy gate, and an edge during ISSUE that must be ignored.
    i_busy     = 1'b1;
    i_tx_valid = 1'b1;
    exp_q.push_back({4'h3, 3'b101});
    repeat (4) begin
      @(negedge clk);
      check("busy_blocks_grant", 32'(o_valid), 32'd0);
    end
    i_busy = 1'b0;
    @(negedge clk);
    check("busy_release_valid", 32'(o_valid), 32'd1);
    pulse_edge();
    check("issue_edge_ignored", 32'(o_tx_done), 32'd0);
    check("msg_held_after_issue", 32'(o_sideband_message), 32'h3);
    done_q.push_back(2'b10);
    repeat (4) @(negedge clk);
    pulse_edge();
    check("wait_edge_done", 32'(o_tx_done), 32'd1);
    i_tx_valid = 1'b0;
    @(negedge clk);
    check("done_single_cycle", 32'(o_tx_done), 32'd0);

    // Timeout: RX granted, sideband never completes.
    i_rx_message = 4'h9;
    i_rx_valid   = 1'b1;
    exp_q.push_back({4'h9, 3'b000});
    wait_valid(4);
    i_rx_valid = 1'b0;
    for (int k = 1; k <= HOLD_TIMEOUT; k++) begin
      @(negedge clk);
      check("timeout_not_yet", 32'(o_timeout), 32'd0);
    end
    @(negedge clk);
    check("timeout_set", 32'(o_timeout), 32'd1);
    repeat (3) begin
      @(negedge clk);
      check("timeout_sticky", 32'(o_timeout), 32'd1);
    end
    i_en = 1'b0;
    @(negedge clk);
    check("timeout_cleared_by_en", 32'(o_timeout), 32'd0);
    i_en = 1'b1;

    // Mid-operation disable during WAIT.
    i_tx_message        = 4'hA;
    i_tx_lanes_encoding = 3'b011;
    i_tx_valid          = 1'b1;
    exp_q.push_back({4'hA, 3'b011});
    wait_valid(4);
    i_tx_valid = 1'b0;
    repeat (2) @(negedge clk);
    i_en = 1'b0;
    @(negedge clk);
    check("disable_outputs", all_outs(), 32'd0);
    i_en = 1'b1;
    @(negedge clk);
    pulse_edge();
    check("disable_no_done", 32'(o_tx_done), 32'd0);
    repeat (2) @(negedge clk);

    check("sends_left", 32'(exp_q.size()), 32'd0);
    check("dones_left", 32'(done_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
